mem_arbiter: RTL and testbench

- Sequences the single-port system memory and shares it between three requesters: loader/DMA (ldr), instruction fetcher (fch) and decoder data path (dat).
- Sits between the requesters and the mem block, replacing the hard manual/fetcher address mux.
- Lets memory be filled over the ldr port while the CPU core is held in reset.
- Provides fixed-plus-round-robin priority, ldr burst lock and a starvation guard.

---
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the single-port system memory: loader, fetcher and
// decoder data path share it through an IDLE/ISSUE/RESP handshake.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic                  ldr_lock,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic                  ldr_gnt,
  output logic                  ldr_rvalid,
  input  logic                  fch_req,
  input  logic [ADDR_WIDTH-1:0] fch_addr,
  output logic                  fch_gnt,
  output logic                  fch_rvalid,
  input  logic                  dat_req,
  input  logic                  dat_we,
  input  logic [ADDR_WIDTH-1:0] dat_addr,
  input  logic [DATA_WIDTH-1:0] dat_wdata,
  output logic                  dat_gnt,
  output logic                  dat_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_LDR  = 2'd1;
  localparam logic [1:0] OWN_FCH  = 2'd2;
  localparam logic [1:0] OWN_DAT  = 2'd3;
  localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  we_reg, we_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            owner_reg, owner_next;
  logic                  rr_dat_reg, rr_dat_next;  // rr_last: 1 = dat, 0 = fch
  logic [2:0]            rvalid_reg;               // {dat, fch, ldr}
  logic [1:0]            starve_req, starve_gnt, starved;
  logic [1:0]            win;
  logic                  lock_cont;

  assign starve_req = {dat_req, fch_req};
  assign starve_gnt = {dat_gnt, fch_gnt};

  // Per-port wait counters for fch (0) and dat (1); starvation needs a live request.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wait
      logic [7:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= 8'd0;
        end else if (!starve_req[gi] || starve_gnt[gi]) begin
          cnt_reg <= 8'd0;
        end else if (cnt_reg != LIMIT) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
      assign starved[gi] = starve_req[gi] && (cnt_reg == LIMIT);
    end
  endgenerate

  always_comb begin
    win = OWN_NONE;
    if (starved == 2'b11)        win = rr_dat_reg ? OWN_FCH : OWN_DAT;
    else if (starved[0])         win = OWN_FCH;
    else if (starved[1])         win = OWN_DAT;
    else if (ldr_req)            win = OWN_LDR;
    else if (fch_req && dat_req) win = rr_dat_reg ? OWN_FCH : OWN_DAT;
    else if (fch_req)            win = OWN_FCH;
    else if (dat_req)            win = OWN_DAT;
  end

  assign lock_cont = (owner_reg == OWN_LDR) && ldr_lock && ldr_req && (starved == 2'b00);

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    we_next     = we_reg;
    wdata_next  = wdata_reg;
    owner_next  = owner_reg;
    rr_dat_next = rr_dat_reg;
    case (state_reg)
      IDLE: begin
        case (win)
          OWN_LDR: begin addr_next = ldr_addr; we_next = ldr_we; wdata_next = ldr_wdata; end
          OWN_FCH: begin addr_next = fch_addr; we_next = 1'b0; end
          OWN_DAT: begin addr_next = dat_addr; we_next = dat_we; wdata_next = dat_wdata; end
          default: ;
        endcase
        if (win != OWN_NONE) begin
          owner_next = win;
          state_next = ISSUE;
        end
        if (win == OWN_FCH || win == OWN_DAT) rr_dat_next = (win == OWN_DAT);
      end
      ISSUE:   state_next = we_reg ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Burst lock: chain the next loader access on the last cycle of the current one.
    if (((state_reg == ISSUE && we_reg) || state_reg == RESP) && lock_cont) begin
      addr_next  = ldr_addr;
      we_next    = ldr_we;
      wdata_next = ldr_wdata;
      state_next = ISSUE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      owner_reg  <= OWN_NONE;
      rr_dat_reg <= 1'b1;
      rdata_reg  <= '0;
      rvalid_reg <= 3'b000;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      we_reg     <= we_next;
      wdata_reg  <= wdata_next;
      owner_reg  <= owner_next;
      rr_dat_reg <= rr_dat_next;
      if (state_reg == RESP) begin
        rdata_reg  <= mem_rdata;
        rvalid_reg <= {owner_reg == OWN_DAT, owner_reg == OWN_FCH, owner_reg == OWN_LDR};
      end else begin
        rvalid_reg <= 3'b000;
      end
    end
  end

  assign ldr_gnt    = (state_reg == ISSUE) && (owner_reg == OWN_LDR);
  assign fch_gnt    = (state_reg == ISSUE) && (owner_reg == OWN_FCH);
  assign dat_gnt    = (state_reg == ISSUE) && (owner_reg == OWN_DAT);
  assign ldr_rvalid = rvalid_reg[0];
  assign fch_rvalid = rvalid_reg[1];
  assign dat_rvalid = rvalid_reg[2];
  assign rdata      = rdata_reg;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_we     = (state_reg == ISSUE) && we_reg;
  assign busy       = (state_reg != IDLE);
  assign owner      = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: queue-driven requesters, a transaction
// scoreboard over a memory model, directed corner cases and random traffic.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          ldr_req = 0, ldr_we = 0, ldr_lock = 0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_gnt, ldr_rvalid;
  logic          fch_req = 0;
  logic [AW-1:0] fch_addr = '0;
  logic          fch_gnt, fch_rvalid;
  logic          dat_req = 0, dat_we = 0;
  logic [AW-1:0] dat_addr = '0;
  logic [DW-1:0] dat_wdata = '0;
  logic          dat_gnt, dat_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
  logic [1:0]    owner;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(rst),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
    .fch_req(fch_req), .fch_addr(fch_addr), .fch_gnt(fch_gnt), .fch_rvalid(fch_rvalid),
    .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr), .dat_wdata(dat_wdata),
    .dat_gnt(dat_gnt), .dat_rvalid(dat_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Synchronous single-port RAM standing in for the mem block.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {logic [AW-1:0] addr; logic we; logic [DW-1:0] data; logic lock;} item_t;
  typedef struct {int cyc; int port; logic [AW-1:0] addr; logic we; logic [DW-1:0] data; int waited;} log_t;
  typedef struct {bit l; bit f; bit d; int exp_port;} vec_t;

  item_t         q [3][$];   // per requester: 0 ldr, 1 fch, 2 dat
  logic [DW-1:0] model [0:65535];
  int            pend_port[$];
  int            pend_due[$];
  logic [DW-1:0] pend_data[$];
  log_t          glog[$];
  log_t          rlog[$];
  int            since[3];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic item_t mk(input int a, input bit w, input int d, input bit lk);
    item_t it;
    it.addr = AW'(a); it.we = w; it.data = DW'(d); it.lock = lk;
    return it;
  endfunction

  // Requester drivers plus transaction scoreboard, evaluated 1 time unit after each edge.
  initial begin
    logic [2:0] gv, rv;
    bit         popped[3];
    bit         exp_rv;
    int         p;
    item_t      it;
    log_t       lg;
    forever begin
      @(posedge clk); #1;
      cyc++;
      popped = '{0, 0, 0};
      if (rst) begin
        ldr_req = 0; ldr_lock = 0; fch_req = 0; dat_req = 0;
        continue;
      end
      rv = {dat_rvalid, fch_rvalid, ldr_rvalid};
      for (int i = 0; i < 3; i++) begin
        exp_rv = (pend_due.size() > 0) && (pend_due[0] == cyc) && (pend_port[0] == i);
        chk($sformatf("rvalid[%0d]", i), rv[i], exp_rv);
        if (exp_rv && rv[i]) begin
          chk("rdata", rdata, pend_data[0]);
          lg = '{cyc, i + 1, '0, 1'b0, rdata, 0};
          rlog.push_back(lg);
        end
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        void'(pend_port.pop_front()); void'(pend_due.pop_front()); void'(pend_data.pop_front());
      end
      gv = {dat_gnt, fch_gnt, ldr_gnt};
      if (gv != 3'b000) begin
        chk("gnt_onehot", $countones(gv), 1);
        p = ldr_gnt ? 0 : (fch_gnt ? 1 : 2);
        chk("gnt_owner", owner, p + 1);
        chk("gnt_busy", busy, 1);
        chk("gnt_has_req", q[p].size() > 0, 1);
        if (q[p].size() > 0) begin
          it = q[p][0];
          chk("mem_addr", mem_addr, it.addr);
          chk("mem_we", mem_we, it.we);
          if (it.we) begin
            chk("mem_wdata", mem_wdata, it.data);
            model[it.addr] = it.data;
          end else begin
            pend_port.push_back(p); pend_due.push_back(cyc + 2); pend_data.push_back(model[it.addr]);
          end
          if (p > 0) chk("starve_bound", (cyc - since[p]) <= 2 * SL + 8, 1);
          lg = '{cyc, p + 1, it.addr, it.we, it.data, cyc - since[p]};
          glog.push_back(lg);
          void'(q[p].pop_front());
          popped[p] = 1;
        end
      end else begin
        chk("mem_we_idle", mem_we, 0);
      end
      if (q[0].size() > 0) begin
        if (!ldr_req || popped[0]) since[0] = cyc;
        ldr_req = 1; ldr_we = q[0][0].we; ldr_lock = q[0][0].lock;
        ldr_addr = q[0][0].addr; ldr_wdata = q[0][0].data;
      end else begin
        ldr_req = 0; ldr_lock = 0;
      end
      if (q[1].size() > 0) begin
        if (!fch_req || popped[1]) since[1] = cyc;
        fch_req = 1; fch_addr = q[1][0].addr;
      end else begin
        fch_req = 0;
      end
      if (q[2].size() > 0) begin
        if (!dat_req || popped[2]) since[2] = cyc;
        dat_req = 1; dat_we = q[2][0].we; dat_addr = q[2][0].addr; dat_wdata = q[2][0].data;
      end else begin
        dat_req = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 3; i++) q[i].delete();
    pend_port.delete(); pend_due.delete(); pend_data.delete();
    glog.delete(); rlog.delete();
  endtask

  task automatic do_reset();
    rst = 1;
    clear_all();
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int  n = 0;
    bit  done = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) &&
             (pend_due.size() == 0) && !busy;
    end
    chk("idle_timeout", done, 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   n;
    int   di;
    bit   ldr_after;
    vecs[0] = '{1, 1, 1, 1};
    vecs[1] = '{0, 1, 1, 2};
    vecs[2] = '{0, 0, 1, 3};
    vecs[3] = '{0, 1, 0, 2};
    vecs[4] = '{1, 0, 1, 1};
    vecs[5] = '{1, 1, 0, 1};
    vecs[6] = '{0, 0, 0, 0};
    for (int i = 0; i < 65536; i++) begin ram[i] = '0; model[i] = '0; end

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_gnt", {ldr_gnt, fch_gnt, dat_gnt}, 0);
    chk("rst_rvalid", {ldr_rvalid, fch_rvalid, dat_rvalid}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rdata", rdata, 0);

    // Arbitration table: first winner after reset
    foreach (vecs[v]) begin
      do_reset();
      if (vecs[v].l) q[0].push_back(mk(16'h0040, 0, 0, 0));
      if (vecs[v].f) q[1].push_back(mk(16'h0041, 0, 0, 0));
      if (vecs[v].d) q[2].push_back(mk(16'h0042, 0, 0, 0));
      n = 0;
      while (glog.size() == 0 && n < 6) begin tick(); n++; end
      if (vecs[v].exp_port == 0) begin
        chk("arb_none_count", glog.size(), 0);
        chk("arb_none_busy", busy, 0);
      end else begin
        chk("arb_winner", glog.size() > 0 ? glog[0].port : 0, vecs[v].exp_port);
        chk("arb_owner", owner, vecs[v].exp_port);
      end
      wait_idle(40);
    end

    // Post-reset write then read on ldr
    do_reset();
    q[0].push_back(mk(16'h0200, 1, 8'hA5, 0));
    q[0].push_back(mk(16'h0200, 0, 0, 0));
    wait_idle(30);
    chk("wr_rd_grants", glog.size(), 2);
    chk("wr_rd_reads", rlog.size(), 1);
    if (glog.size() == 2 && rlog.size() == 1) begin
      chk("wr_to_rd_gap", glog[1].cyc - glog[0].cyc, 2);
      chk("rd_latency", rlog[0].cyc - glog[1].cyc, 2);
      chk("rd_port", rlog[0].port, 1);
      chk("rd_data", rlog[0].data, 8'hA5);
    end

    // Locked 16-write burst, then fch readback
    do_reset();
    for (int i = 0; i < 16; i++) q[0].push_back(mk(16'h0600 + i, 1, i, 1));
    wait_idle(60);
    chk("burst_grants", glog.size(), 16);
    if (glog.size() == 16) chk("burst_span", glog[15].cyc - glog[0].cyc, 15);
    glog.delete(); rlog.delete();
    for (int i = 0; i < 16; i++) q[1].push_back(mk(16'h0600 + i, 0, 0, 0));
    wait_idle(100);
    chk("burst_readback_count", rlog.size(), 16);
    for (int i = 0; i < rlog.size() && i < 16; i++) chk($sformatf("burst_rd[%0d]", i), rlog[i].data, i);

    // Round-robin between fch and dat
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q[1].push_back(mk(16'h0600 + i, 0, 0, 0));
      q[2].push_back(mk(16'h0608 + i, 0, 0, 0));
    end
    wait_idle(60);
    chk("rr_grants", glog.size(), 8);
    for (int i = 0; i < glog.size() && i < 8; i++)
      chk($sformatf("rr_order[%0d]", i), glog[i].port, (i % 2 == 0) ? 2 : 3);

    // Starvation guard breaks a loader lock burst
    do_reset();
    for (int i = 0; i < 40; i++) q[0].push_back(mk(16'h0700 + i, 1, 8'h80 + i, 1));
    tick(); tick(); tick();
    q[2].push_back(mk(16'h0603, 0, 0, 0));
    wait_idle(200);
    di = -1;
    foreach (glog[i]) if (glog[i].port == 3 && di < 0) di = i;
    chk("starve_dat_granted", di >= 0, 1);
    ldr_after = 0;
    if (di >= 0) begin
      chk("starve_delay", glog[di].waited, SL + 2);
      for (int i = di + 1; i < glog.size(); i++) if (glog[i].port == 1) ldr_after = 1;
      chk("starve_ldr_resumes", ldr_after, 1);
    end

    // Reset during RESP of an fch read
    do_reset();
    q[1].push_back(mk(16'h0603, 0, 0, 0));
    n = 0;
    while (glog.size() == 0 && n < 8) begin tick(); n++; end
    chk("midrst_granted", glog.size(), 1);
    tick();
    chk("midrst_busy_before", busy, 1);
    rst = 1;
    #1;
    chk("midrst_gnt", {ldr_gnt, fch_gnt, dat_gnt}, 0);
    chk("midrst_rvalid", {ldr_rvalid, fch_rvalid, dat_rvalid}, 0);
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_owner", owner, 0);
    clear_all();
    tick(); tick();
    rst = 0;
    repeat (5) tick();
    chk("midrst_no_rvalid", rlog.size(), 0);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_owner_after", owner, 0);

    // dat write with req dropped during ISSUE, then readback
    do_reset();
    q[2].push_back(mk(16'h0010, 1, 8'h3C, 0));
    wait_idle(20);
    chk("drop_write_granted", glog.size(), 1);
    rlog.delete();
    q[1].push_back(mk(16'h0010, 0, 0, 0));
    wait_idle(20);
    chk("drop_readback_count", rlog.size(), 1);
    if (rlog.size() == 1) chk("drop_readback", rlog[0].data, 8'h3C);

    // Random traffic against the scoreboard
    do_reset();
    for (int t = 0; t < 500; t++) begin
      for (int p = 0; p < 3; p++) begin
        if (q[p].size() < 3 && $urandom_range(0, 3) == 0)
          q[p].push_back(mk($urandom_range(0, 31), (p == 1) ? 1'b0 : 1'($urandom_range(0, 1)),
                            $urandom_range(0, 255), (p == 0) ? 1'($urandom_range(0, 1)) : 1'b0));
      end
      tick();
    end
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
